// File: rtl/ddr_burst_arbiter_if.sv
// ddr_burst_arbiter_if
//   Bundles every signal between the DDR burst arbiter, its two requesters
//   (display line fetcher, Life engine) and the DDR controller port.
//   master : arbiter view (drives grants, beat strobes, command, stats)
//   slave  : environment view (requesters + controller drive requests,
//            write data, command ready and read beats)
//   Signal groups:
//     disp_*  display request/grant/read-valid/done
//     eng_*   engine request/grant/write-next/read-valid/done
//     rd_data shared registered read data
//     mem_*   DDR controller command, write and read channels
//     busy, stat_*  status and optional statistics (ARB_STATS_EN)
interface ddr_burst_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 6
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [LEN_W-1:0]  disp_len;
  logic              disp_grant;
  logic              disp_rd_valid;
  logic              disp_done;

  logic              eng_req;
  logic              eng_we;
  logic [ADDR_W-1:0] eng_addr;
  logic [LEN_W-1:0]  eng_len;
  logic [DATA_W-1:0] eng_wr_data;
  logic              eng_grant;
  logic              eng_wr_next;
  logic              eng_rd_valid;
  logic              eng_done;

  logic [DATA_W-1:0] rd_data;

  logic              mem_cmd_valid;
  logic              mem_cmd_ready;
  logic              mem_cmd_we;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic [LEN_W-1:0]  mem_cmd_len;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_ready;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_valid;

  logic              busy;
  logic [15:0]       stat_disp_grants;
  logic [15:0]       stat_eng_grants;
  logic [15:0]       stat_eng_wait;

  modport master (
    input  disp_req, disp_addr, disp_len,
    output disp_grant, disp_rd_valid, disp_done,
    input  eng_req, eng_we, eng_addr, eng_len, eng_wr_data,
    output eng_grant, eng_wr_next, eng_rd_valid, eng_done,
    output rd_data,
    output mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_len, mem_wr_data,
    input  mem_cmd_ready, mem_wr_ready, mem_rd_data, mem_rd_valid,
    output busy, stat_disp_grants, stat_eng_grants, stat_eng_wait
  );

  modport slave (
    output disp_req, disp_addr, disp_len,
    input  disp_grant, disp_rd_valid, disp_done,
    output eng_req, eng_we, eng_addr, eng_len, eng_wr_data,
    input  eng_grant, eng_wr_next, eng_rd_valid, eng_done,
    input  rd_data,
    input  mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_len, mem_wr_data,
    output mem_cmd_ready, mem_wr_ready, mem_rd_data, mem_rd_valid,
    input  busy, stat_disp_grants, stat_eng_grants, stat_eng_wait
  );
endinterface

// File: rtl/ddr_burst_arbiter.sv
// ddr_burst_arbiter
//   Shares the DDR controller command/data port between the display line
//   fetcher (read-only, hard deadline) and the Life generation engine
//   (read/write). One burst at a time: arbitrate, issue command, count data
//   beats, release.
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-high
//   bus  ddr_burst_arbiter_if.master: requester handshakes, DDR command /
//        write / read channels, busy flag and statistics counters
// Optional feature macro: ARB_STATS_EN
//   defined   -> 16-bit saturating grant / engine-wait counters are built
//   undefined -> stat_* outputs are tied to zero
module ddr_burst_arbiter #(
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 6,
  parameter int MAX_DISP_RUN = 4
) (
  input  logic                clk,
  input  logic                rst,
  ddr_burst_arbiter_if.master bus
);

  localparam int RUN_W = (MAX_DISP_RUN < 1) ? 1 : $clog2(MAX_DISP_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DISP_RUN);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

  state_t            state, state_nxt;
  logic              owner_eng;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [LEN_W-1:0]  beat_cnt;
  logic [RUN_W-1:0]  run_cnt;

  logic              disp_win, eng_win;
  logic              cmd_accept;
  logic              beat;
  logic              rd_beat;

  logic              disp_grant_q, eng_grant_q;
  logic              disp_done_q, eng_done_q;
  logic              disp_rd_vld_p1, eng_rd_vld_p1;
  logic [DATA_W-1:0] rd_data_p1;

  function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] v);
    return (v >= RUN_MAX) ? RUN_MAX : v + RUN_W'(1);
  endfunction

  // Next state and arbitration. The display normally wins; once it has
  // taken MAX_DISP_RUN grants in a row over a waiting engine, the engine
  // gets the next slot.
  always_comb begin
    state_nxt  = state;
    disp_win   = 1'b0;
    eng_win    = 1'b0;
    cmd_accept = 1'b0;
    beat       = 1'b0;
    rd_beat    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.disp_req && !((run_cnt == RUN_MAX) && bus.eng_req)) begin
          disp_win = 1'b1;
        end else if (bus.eng_req) begin
          eng_win = 1'b1;
        end
        if (disp_win || eng_win) state_nxt = S_CMD;
      end
      S_CMD: begin
        if (bus.mem_cmd_ready) begin
          cmd_accept = 1'b1;
          state_nxt  = S_DATA;
        end
      end
      S_DATA: begin
        beat    = cmd_we ? bus.mem_wr_ready : bus.mem_rd_valid;
        rd_beat = !cmd_we && bus.mem_rd_valid;
        if (beat && (beat_cnt == '0)) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p0 -> p1: state, latched command, beat counter, registered read beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      owner_eng      <= 1'b0;
      cmd_we         <= 1'b0;
      cmd_addr       <= '0;
      cmd_len        <= '0;
      beat_cnt       <= '0;
      run_cnt        <= '0;
      disp_grant_q   <= 1'b0;
      eng_grant_q    <= 1'b0;
      disp_done_q    <= 1'b0;
      eng_done_q     <= 1'b0;
      disp_rd_vld_p1 <= 1'b0;
      eng_rd_vld_p1  <= 1'b0;
      rd_data_p1     <= '0;
    end else begin
      state        <= state_nxt;
      disp_grant_q <= disp_win;
      eng_grant_q  <= eng_win;

      if (disp_win) begin
        owner_eng <= 1'b0;
        cmd_we    <= 1'b0;
        cmd_addr  <= bus.disp_addr;
        cmd_len   <= bus.disp_len;
        // Only a run of grants taken over a waiting engine counts.
        run_cnt   <= bus.eng_req ? run_sat_inc(run_cnt) : '0;
      end else if (eng_win) begin
        owner_eng <= 1'b1;
        cmd_we    <= bus.eng_we;
        cmd_addr  <= bus.eng_addr;
        cmd_len   <= bus.eng_len;
        run_cnt   <= '0;
      end

      // Counter holds at zero on the final beat so max length never wraps.
      if (cmd_accept) begin
        beat_cnt <= cmd_len;
      end else if (beat && (beat_cnt != '0)) begin
        beat_cnt <= beat_cnt - LEN_W'(1);
      end

      if (rd_beat) rd_data_p1 <= bus.mem_rd_data;
      disp_rd_vld_p1 <= rd_beat && !owner_eng;
      eng_rd_vld_p1  <= rd_beat && owner_eng;

      disp_done_q <= (state == S_DONE) && !owner_eng;
      eng_done_q  <= (state == S_DONE) && owner_eng;
    end
  end

  assign bus.disp_grant    = disp_grant_q;
  assign bus.eng_grant     = eng_grant_q;
  assign bus.disp_done     = disp_done_q;
  assign bus.eng_done      = eng_done_q;
  assign bus.disp_rd_valid = disp_rd_vld_p1;
  assign bus.eng_rd_valid  = eng_rd_vld_p1;
  assign bus.rd_data       = rd_data_p1;

  assign bus.mem_cmd_valid = (state == S_CMD);
  assign bus.mem_cmd_we    = cmd_we;
  assign bus.mem_cmd_addr  = cmd_addr;
  assign bus.mem_cmd_len   = cmd_len;
  assign bus.mem_wr_data   = bus.eng_wr_data;
  assign bus.eng_wr_next   = (state == S_DATA) && cmd_we && bus.mem_wr_ready;
  assign bus.busy          = (state != S_IDLE);

`ifdef ARB_STATS_EN
  logic [15:0] stat_disp_q, stat_eng_q, stat_wait_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A waiting cycle is one where the engine asks, is not picked this
  // cycle, and is not already seeing its grant pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_disp_q <= '0;
      stat_eng_q  <= '0;
      stat_wait_q <= '0;
    end else begin
      if (disp_win) stat_disp_q <= sat_inc16(stat_disp_q);
      if (eng_win)  stat_eng_q  <= sat_inc16(stat_eng_q);
      if (bus.eng_req && !eng_win && !eng_grant_q) stat_wait_q <= sat_inc16(stat_wait_q);
    end
  end

  assign bus.stat_disp_grants = stat_disp_q;
  assign bus.stat_eng_grants  = stat_eng_q;
  assign bus.stat_eng_wait    = stat_wait_q;
`else
  assign bus.stat_disp_grants = '0;
  assign bus.stat_eng_grants  = '0;
  assign bus.stat_eng_wait    = '0;
`endif

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// tb_ddr_burst_arbiter
//   Directed bench for ddr_burst_arbiter: reset state, display read burst,
//   engine write burst with throttled write ready, starvation guard grant
//   order, command stall, reset mid-burst, maximum burst length and the
//   optional statistics counters (ARB_STATS_EN).
module tb_ddr_burst_arbiter;
  localparam int ADDR_W       = 24;
  localparam int DATA_W       = 32;
  localparam int LEN_W        = 6;
  localparam int MAX_DISP_RUN = 4;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  ddr_burst_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  ddr_burst_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_DISP_RUN(MAX_DISP_RUN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wdat(input int i);
    return 32'hC0DE_0000 + i;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.disp_req = 0; bus.disp_addr = '0; bus.disp_len = '0;
    bus.eng_req = 0; bus.eng_we = 0; bus.eng_addr = '0; bus.eng_len = '0; bus.eng_wr_data = '0;
    bus.mem_cmd_ready = 0; bus.mem_wr_ready = 0; bus.mem_rd_data = '0; bus.mem_rd_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy: got %b, expected 0", bus.busy);
    end
    tests_run++;
    if ({bus.mem_cmd_valid, bus.disp_grant, bus.eng_grant, bus.disp_done, bus.eng_done} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b, expected 00000",
               {bus.mem_cmd_valid, bus.disp_grant, bus.eng_grant, bus.disp_done, bus.eng_done});
    end
    tests_run++;
    if ({bus.mem_cmd_addr, bus.mem_cmd_len, bus.rd_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_fields: got addr %0h len %0d rd %0h, expected 0", bus.mem_cmd_addr, bus.mem_cmd_len, bus.rd_data);
    end
    tests_run++;
    if ({bus.stat_disp_grants, bus.stat_eng_grants, bus.stat_eng_wait} !== 48'h0) begin
      tests_failed++;
      $display("FAIL reset_stats: got %0d %0d %0d, expected 0 0 0", bus.stat_disp_grants, bus.stat_eng_grants, bus.stat_eng_wait);
    end
  endtask

  task automatic test_disp_read();
    logic [31:0] exp_d [4];
    int sent, rcv, dn, edn, erv;
    bit got, data_ph;
    exp_d = '{32'hDEAD_0001, 32'h0BAD_F00D, 32'h1234_5678, 32'hFFFF_0000};
    @(posedge clk); #1;
    bus.disp_addr = 24'h123456; bus.disp_len = 6'd3; bus.disp_req = 1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk); got = bus.disp_grant;
    end
    tests_run++;
    if (!got) begin tests_failed++; $display("FAIL disp_grant: got no grant, expected grant within 10 cycles"); end
    tests_run++;
    if ({bus.mem_cmd_valid, bus.mem_cmd_we, bus.mem_cmd_addr, bus.mem_cmd_len} !== {1'b1, 1'b0, 24'h123456, 6'd3}) begin
      tests_failed++;
      $display("FAIL disp_cmd: got v%b we%b %0h len %0d, expected v1 we0 123456 len 3",
               bus.mem_cmd_valid, bus.mem_cmd_we, bus.mem_cmd_addr, bus.mem_cmd_len);
    end
    data_ph = bus.mem_cmd_valid && bus.mem_cmd_ready;
    sent = 0; rcv = 0; dn = 0; edn = 0; erv = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      bus.disp_req = 0;
      bus.mem_cmd_ready = (c >= 2);
      if (!data_ph) begin
        // beats outside DATA must be ignored
        bus.mem_rd_valid = 1; bus.mem_rd_data = 32'hBAD0_BAD0;
      end else if (sent < 4 && c[0]) begin
        bus.mem_rd_valid = 1; bus.mem_rd_data = exp_d[sent]; sent++;
      end else begin
        bus.mem_rd_valid = 0;
      end
      @(negedge clk);
      if (bus.mem_cmd_valid && bus.mem_cmd_ready) data_ph = 1;
      if (bus.disp_rd_valid) begin
        if (rcv < 4) begin
          tests_run++;
          if (bus.rd_data !== exp_d[rcv]) begin
            tests_failed++; $display("FAIL disp_data[%0d]: got %h, expected %h", rcv, bus.rd_data, exp_d[rcv]);
          end
        end
        rcv++;
      end
      if (bus.disp_done) dn++;
      if (bus.eng_done) edn++;
      if (bus.eng_rd_valid) erv++;
    end
    bus.mem_cmd_ready = 0;
    tests_run++;
    if (rcv != 4) begin tests_failed++; $display("FAIL disp_beats: got %0d, expected 4", rcv); end
    tests_run++;
    if (dn != 1) begin tests_failed++; $display("FAIL disp_done: got %0d pulses, expected 1", dn); end
    tests_run++;
    if (edn + erv != 0) begin tests_failed++; $display("FAIL disp_eng_quiet: got %0d engine strobes, expected 0", edn + erv); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL disp_idle: got busy %b, expected 0", bus.busy); end
  endtask

  task automatic test_eng_write();
    int idx, nxt, dn, erv;
    bit got, data_ph, consumed;
    @(posedge clk); #1;
    bus.eng_req = 1; bus.eng_we = 1; bus.eng_addr = 24'hABCDE0; bus.eng_len = 6'd7;
    bus.eng_wr_data = wdat(0); bus.mem_cmd_ready = 1; bus.mem_wr_ready = 0;
    bus.mem_rd_valid = 1; bus.mem_rd_data = 32'h7777_7777;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk); got = bus.eng_grant;
    end
    tests_run++;
    if (!got) begin tests_failed++; $display("FAIL eng_grant: got no grant, expected grant within 10 cycles"); end
    tests_run++;
    if ({bus.mem_cmd_we, bus.mem_cmd_addr, bus.mem_cmd_len} !== {1'b1, 24'hABCDE0, 6'd7}) begin
      tests_failed++;
      $display("FAIL eng_cmd: got we%b %0h len %0d, expected we1 abcde0 len 7", bus.mem_cmd_we, bus.mem_cmd_addr, bus.mem_cmd_len);
    end
    data_ph = bus.mem_cmd_valid && bus.mem_cmd_ready;
    idx = 0; nxt = 0; dn = 0; erv = 0; consumed = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      bus.eng_req = 0;
      if (consumed) begin idx++; bus.eng_wr_data = wdat(idx); consumed = 0; end
      bus.mem_wr_ready = data_ph ? !bus.mem_wr_ready : 1'b0;
      @(negedge clk);
      if (bus.mem_cmd_valid && bus.mem_cmd_ready) data_ph = 1;
      if (bus.eng_wr_next) begin
        tests_run++;
        if (bus.mem_wr_data !== wdat(idx)) begin
          tests_failed++; $display("FAIL eng_wr_data[%0d]: got %h, expected %h", idx, bus.mem_wr_data, wdat(idx));
        end
        nxt++; consumed = 1;
      end
      if (bus.eng_done) dn++;
      if (bus.eng_rd_valid) erv++;
    end
    bus.mem_wr_ready = 0; bus.mem_rd_valid = 0; bus.mem_cmd_ready = 0;
    tests_run++;
    if (nxt != 8) begin tests_failed++; $display("FAIL eng_wr_next: got %0d, expected 8", nxt); end
    tests_run++;
    if (dn != 1) begin tests_failed++; $display("FAIL eng_done: got %0d pulses, expected 1", dn); end
    tests_run++;
    if (erv != 0) begin tests_failed++; $display("FAIL eng_wr_rdvalid: got %0d, expected 0", erv); end
  endtask

  task automatic test_starvation();
    logic [9:0] exp_e;
    int n;
    exp_e = 10'b10_0001_0000;  // bit n set: grant n goes to the engine
    do_reset();
    @(posedge clk); #1;
    bus.disp_req = 1; bus.disp_addr = 24'h000001; bus.disp_len = 0;
    bus.eng_req = 1; bus.eng_we = 0; bus.eng_addr = 24'h000002; bus.eng_len = 0;
    bus.mem_cmd_ready = 1; bus.mem_rd_valid = 1; bus.mem_rd_data = 32'h1;
    n = 0;
    for (int c = 0; c < 200 && n < 10; c++) begin
      @(negedge clk);
      if (bus.disp_grant || bus.eng_grant) begin
        tests_run++;
        if ({bus.disp_grant, bus.eng_grant} !== (exp_e[n] ? 2'b01 : 2'b10)) begin
          tests_failed++;
          $display("FAIL grant_order[%0d]: got d%b e%b, expected %s", n, bus.disp_grant, bus.eng_grant, exp_e[n] ? "E" : "D");
        end
        n++;
      end
    end
    tests_run++;
    if (n != 10) begin tests_failed++; $display("FAIL grant_count: got %0d, expected 10", n); end
    @(posedge clk); #1;
    bus.disp_req = 0; bus.eng_req = 0;
    for (int c = 0; c < 20 && bus.busy; c++) @(negedge clk);
    @(posedge clk); #1;
    bus.mem_rd_valid = 0; bus.mem_cmd_ready = 0;
  endtask

  task automatic test_cmd_stall();
    bit got;
    @(posedge clk); #1;
    bus.disp_req = 1; bus.disp_addr = 24'h0F0F0F; bus.disp_len = 6'd5;
    bus.mem_cmd_ready = 0; bus.mem_rd_valid = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk); got = bus.disp_grant;
    end
    tests_run++;
    if (!got) begin tests_failed++; $display("FAIL stall_grant: got no grant, expected grant within 10 cycles"); end
    @(posedge clk); #1;
    bus.disp_req = 0; bus.disp_addr = 24'h000111; bus.disp_len = 6'd1;
    bus.eng_req = 1; bus.eng_we = 1; bus.eng_addr = 24'hFFFFFF; bus.eng_len = 6'd2;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests_run++;
      if ({bus.mem_cmd_valid, bus.mem_cmd_we, bus.mem_cmd_addr, bus.mem_cmd_len, bus.disp_grant, bus.eng_grant}
          !== {1'b1, 1'b0, 24'h0F0F0F, 6'd5, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: got v%b we%b %0h len %0d dg%b eg%b, expected v1 we0 f0f0f len 5 dg0 eg0",
                 c, bus.mem_cmd_valid, bus.mem_cmd_we, bus.mem_cmd_addr, bus.mem_cmd_len, bus.disp_grant, bus.eng_grant);
      end
    end
  endtask

  task automatic test_rst_mid_data();
    int dn, bz;
    @(posedge clk); #1;
    bus.eng_req = 0; bus.mem_cmd_ready = 1;
    @(posedge clk); #1;  // CMD -> DATA
    bus.mem_cmd_ready = 0; bus.mem_rd_valid = 1; bus.mem_rd_data = 32'hA5A5_A5A5;
    @(posedge clk); #1;  // first beat taken
    bus.mem_rd_data = 32'h5A5A_5A5A;
    @(negedge clk);
    tests_run++;
    if ({bus.busy, bus.disp_rd_valid, bus.rd_data} !== {1'b1, 1'b1, 32'hA5A5_A5A5}) begin
      tests_failed++;
      $display("FAIL mid_data: got busy%b rv%b %h, expected busy1 rv1 a5a5a5a5", bus.busy, bus.disp_rd_valid, bus.rd_data);
    end
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    bus.mem_rd_valid = 0;
    @(negedge clk);
    tests_run++;
    if ({bus.busy, bus.mem_cmd_valid, bus.mem_cmd_we, bus.disp_grant, bus.eng_grant, bus.disp_rd_valid,
         bus.eng_rd_valid, bus.disp_done, bus.eng_done, bus.eng_wr_next} !== 10'b0) begin
      tests_failed++;
      $display("FAIL rst_ctrl: got %b, expected 0000000000",
               {bus.busy, bus.mem_cmd_valid, bus.mem_cmd_we, bus.disp_grant, bus.eng_grant, bus.disp_rd_valid,
                bus.eng_rd_valid, bus.disp_done, bus.eng_done, bus.eng_wr_next});
    end
    tests_run++;
    if ({bus.mem_cmd_addr, bus.mem_cmd_len, bus.rd_data} !== '0) begin
      tests_failed++;
      $display("FAIL rst_fields: got addr %0h len %0d rd %h, expected 0", bus.mem_cmd_addr, bus.mem_cmd_len, bus.rd_data);
    end
    @(posedge clk); #1;
    rst = 0;
    dn = 0; bz = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.disp_done || bus.eng_done) dn++;
      if (bus.busy) bz++;
    end
    tests_run++;
    if (dn + bz != 0) begin
      tests_failed++; $display("FAIL rst_no_done: got %0d done and %0d busy cycles, expected 0", dn, bz);
    end
  endtask

  task automatic test_max_len();
    int sent, rcv, dn, after;
    bit got, data_ph;
    @(posedge clk); #1;
    bus.eng_req = 1; bus.eng_we = 0; bus.eng_addr = 24'h000040; bus.eng_len = 6'h3F;
    bus.mem_cmd_ready = 1; bus.mem_rd_valid = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk); got = bus.eng_grant;
    end
    tests_run++;
    if (!got || bus.mem_cmd_len !== 6'h3F) begin
      tests_failed++; $display("FAIL max_cmd: got grant %b len %0d, expected grant 1 len 63", got, bus.mem_cmd_len);
    end
    data_ph = bus.mem_cmd_valid && bus.mem_cmd_ready;
    sent = 0; rcv = 0; dn = 0; after = 0;
    for (int c = 0; c < 120 && after < 6; c++) begin
      @(posedge clk); #1;
      bus.eng_req = 0;
      if (data_ph) begin bus.mem_rd_valid = 1; bus.mem_rd_data = 32'h5000_0000 + sent; sent++; end
      @(negedge clk);
      if (bus.mem_cmd_valid && bus.mem_cmd_ready) data_ph = 1;
      if (bus.eng_rd_valid) begin
        if (rcv < 64) begin
          tests_run++;
          if (bus.rd_data !== 32'h5000_0000 + rcv) begin
            tests_failed++; $display("FAIL max_data[%0d]: got %h, expected %h", rcv, bus.rd_data, 32'h5000_0000 + rcv);
          end
        end
        rcv++;
      end
      if (bus.eng_done) dn++;
      if (dn > 0) after++;
    end
    bus.mem_rd_valid = 0; bus.mem_cmd_ready = 0;
    tests_run++;
    if (rcv != 64) begin tests_failed++; $display("FAIL max_beats: got %0d, expected 64", rcv); end
    tests_run++;
    if (dn != 1) begin tests_failed++; $display("FAIL max_done: got %0d pulses, expected 1", dn); end
  endtask

  task automatic test_stats();
    bit got;
    do_reset();
    @(posedge clk); #1;
    bus.disp_req = 1; bus.disp_addr = 24'h000100; bus.disp_len = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk); got = bus.disp_grant;
    end
    @(posedge clk); #1;
    bus.disp_req = 0; bus.eng_req = 1; bus.eng_we = 0; bus.eng_addr = 24'h000200; bus.eng_len = 0;
    @(posedge clk);             // waiting cycle 1 (CMD stalled)
    @(posedge clk); #1;         // waiting cycle 2
    bus.mem_cmd_ready = 1;
    @(posedge clk); #1;         // waiting cycle 3: CMD -> DATA
    bus.mem_cmd_ready = 0; bus.mem_rd_valid = 1;
    @(posedge clk); #1;         // waiting cycle 4: beat -> DONE
    bus.mem_rd_valid = 0;
    @(posedge clk);             // waiting cycle 5: DONE -> IDLE
    @(posedge clk); #1;         // engine picked
    tests_run++;
    if (!got || bus.eng_grant !== 1'b1) begin
      tests_failed++; $display("FAIL stats_grants: got disp %b eng %b, expected 1 1", got, bus.eng_grant);
    end
    bus.eng_req = 0;
    @(negedge clk);
`ifdef ARB_STATS_EN
    tests_run++;
    if ({bus.stat_disp_grants, bus.stat_eng_grants, bus.stat_eng_wait} !== {16'd1, 16'd1, 16'd5}) begin
      tests_failed++;
      $display("FAIL stats_vals: got %0d %0d %0d, expected 1 1 5", bus.stat_disp_grants, bus.stat_eng_grants, bus.stat_eng_wait);
    end
`else
    tests_run++;
    if ({bus.stat_disp_grants, bus.stat_eng_grants, bus.stat_eng_wait} !== 48'h0) begin
      tests_failed++;
      $display("FAIL stats_off: got %0d %0d %0d, expected 0 0 0", bus.stat_disp_grants, bus.stat_eng_grants, bus.stat_eng_wait);
    end
`endif
  endtask

  initial begin
    do_reset();
    test_reset();
    test_disp_read();
    test_eng_write();
    test_starvation();
    test_cmd_stall();
    test_rst_mid_data();
    test_max_len();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
